mymem_arbiter: RTL and testbench
================================

Name: mymem_arbiter

Overview:
- Shares the single-port scratchpad memory between two requesters: the RoCC command path (port 0) and a refill/DMA engine (port 1).
- Accepts ready/valid read and write requests and arbitrates round-robin.
- Drives the memory command port, tracks in-flight reads and routes each fixed-latency read response back to its originator.
- Holds responses in a 1-entry slot per requester so each requester can apply backpressure independently.

Parameters:
ADDR_W, 10, memory word address width
DATA_W, 64, data width
TAG_W, 5, request tag width (e.g. RoCC rd)
MEM_LAT, 1, memory read latency in cycles, from mem_rqvalid to mem_rdvalid (>=1)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
rq0_valid / rq1_valid  in  1  request valid
rq0_ready / rq1_ready  out  1  request accepted this cycle when valid&ready
rq0_wren / rq1_wren  in  1  1=write, 0=read
rq0_addr / rq1_addr  in  ADDR_W  word address
rq0_wrdata / rq1_wrdata  in  DATA_W  write data
rq0_tag / rq1_tag  in  TAG_W  read tag, returned with response
rs0_valid / rs1_valid  out  1  response valid
rs0_ready / rs1_ready  in  1  response consumed
rs0_tag / rs1_tag  out  TAG_W  tag of response
rs0_data / rs1_data  out  DATA_W  read data
mem_rqvalid  out  1  read request to memory
mem_rqaddr  out  TAG_W  tag to memory
mem_wren  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wrdata  out  DATA_W  memory write data
mem_rdvalid  in  1  memory response valid
mem_rdaddr  in  TAG_W  memory response tag
mem_rddata  in  DATA_W  memory response data

Behaviour:
- Clock is `clock`. Reset is `reset`: one clock, synchronous, active-high.
- Eligibility of port i:
  - valid, and
  - either a write, or a read with no read for i in flight and the response slot i empty or popped this cycle (rs_i_valid & rs_i_ready).
- Grant:
  - At most one port is granted per cycle.
  - If both ports are eligible, the port not granted last wins.
  - Last-grant pointer resets to 1, so port 0 wins first. It updates only on a grant.
- rq_i_ready is 1 only for the granted port.
  - It is combinational from eligibility and pointer.
  - It does not depend on rq_i_valid of the same port.
  - It is forced to 0 while reset is high.
- Memory command (combinational, same cycle as the accepted handshake):
  - mem_addr = granted addr.
  - mem_wrdata = granted wrdata.
  - mem_rqaddr = granted tag.
  - mem_wren = granted & wren.
  - mem_rqvalid = granted & !wren.
  - With no grant: mem_wren = mem_rqvalid = 0, and addr/data/tag are don't-care.
- Writes produce no response.
- In-flight tracking: a MEM_LAT-deep shift register of {valid, owner}. Entry pushed on each read grant; it pops when it reaches the end.
- Response capture:
  - When mem_rdvalid coincides with a tracked entry, write {mem_rdaddr, mem_rddata} into slot[owner] and set rs_owner_valid.
  - A mem_rdvalid with no tracked entry is ignored.
- Response slot: rs_i_valid stays set until rs_i_ready. Capture and pop in the same cycle keeps it valid with new contents.
- Latency (MEM_LAT=1): read accepted at cycle t, response visible at t+2. Sustained per-port read rate is 1 per 2 cycles. Aggregate rate is 1 per cycle with both ports alternating.
- Write accepted at t is visible to a read accepted at t+1.
- Reset:
  - Clears slots, in-flight pipeline and pointer.
  - Outputs go to 0: rs*_valid, rq*_ready, mem_rqvalid, mem_wren. rs*_tag/rs*_data also reset to 0.
  - Reads in flight at reset are dropped; their late mem_rdvalid is ignored.

Optional Feature:
- Macro MYMEM_ARB_STATS_EN.
- When defined, adds these outputs:
  - stat_grant0 [31:0] and stat_grant1 [31:0]: accepted requests per port.
  - stat_conflict [31:0]: cycles with both rq*_valid high and only one granted.
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port 0 writes addr 5 = 0xDEADBEEF at t, then reads addr 5 tag 3 at t+1 -> rs0_valid at t+3 with tag 3 and data 0xDEADBEEF; no rs1 activity.
- Both ports hold reads continuously, with rs_ready=1 -> grants alternate 0,1,0,1 starting with port 0; mem_rqvalid high every cycle; each port gets 1 response per 2 cycles with correct tags.
- Port 1 read completes with rs1_ready=0 held 5 cycles while port 1 keeps requesting reads -> rq1_ready=0 throughout; port 0 writes still granted every cycle; after rs1_ready=1, the next port 1 read is granted that same cycle.
- Port 1 write with port 0 read blocked by a full slot -> port 1 granted; mem_wren=1 and mem_rqvalid=0.
- Reset pulsed the cycle after a read grant -> mem_rdvalid arriving during/after reset is ignored; rs0_valid stays 0; next grant goes to port 0.
- With MYMEM_ARB_STATS_EN: 10 cycles of both valid writes -> stat_grant0=5, stat_grant1=5, stat_conflict=10.

Source files
------------

// File: rtl/mymem_arbiter_if.sv
// Request, response and memory-command signals of the two-port scratchpad arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mymem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 5
);
  logic              rq0_valid;
  logic              rq0_ready;
  logic              rq0_wren;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wrdata;
  logic [TAG_W-1:0]  rq0_tag;
  logic              rq1_valid;
  logic              rq1_ready;
  logic              rq1_wren;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wrdata;
  logic [TAG_W-1:0]  rq1_tag;

  logic              rs0_valid;
  logic              rs0_ready;
  logic [TAG_W-1:0]  rs0_tag;
  logic [DATA_W-1:0] rs0_data;
  logic              rs1_valid;
  logic              rs1_ready;
  logic [TAG_W-1:0]  rs1_tag;
  logic [DATA_W-1:0] rs1_data;

  logic              mem_rqvalid;
  logic [TAG_W-1:0]  mem_rqaddr;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrdata;
  logic              mem_rdvalid;
  logic [TAG_W-1:0]  mem_rdaddr;
  logic [DATA_W-1:0] mem_rddata;

  modport slave (
    input  rq0_valid, rq0_wren, rq0_addr, rq0_wrdata, rq0_tag,
    input  rq1_valid, rq1_wren, rq1_addr, rq1_wrdata, rq1_tag,
    input  rs0_ready, rs1_ready,
    input  mem_rdvalid, mem_rdaddr, mem_rddata,
    output rq0_ready, rq1_ready,
    output rs0_valid, rs0_tag, rs0_data, rs1_valid, rs1_tag, rs1_data,
    output mem_rqvalid, mem_rqaddr, mem_wren, mem_addr, mem_wrdata
  );

  modport master (
    output rq0_valid, rq0_wren, rq0_addr, rq0_wrdata, rq0_tag,
    output rq1_valid, rq1_wren, rq1_addr, rq1_wrdata, rq1_tag,
    output rs0_ready, rs1_ready,
    output mem_rdvalid, mem_rdaddr, mem_rddata,
    input  rq0_ready, rq1_ready,
    input  rs0_valid, rs0_tag, rs0_data, rs1_valid, rs1_tag, rs1_data,
    input  mem_rqvalid, mem_rqaddr, mem_wren, mem_addr, mem_wrdata
  );
endinterface

// File: rtl/mymem_arbiter.sv
// Round-robin arbiter sharing a single-port scratchpad between two requesters.
// Define MYMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mymem_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  mymem_arbiter_if.slave       bus
`ifdef MYMEM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_grant0,
  output logic [31:0]          stat_grant1,
  output logic [31:0]          stat_conflict
`endif
);

  localparam int unsigned LastStage = MEM_LAT - 1;

  typedef struct packed {
    logic valid;
    logic owner;
  } flight_t;

  flight_t           pipe_q [MEM_LAT];
  logic [1:0]        rq_valid, rq_wren, rs_ready, rs_pop;
  logic [1:0]        in_flight, can_go, elig, ready, grant;
  logic              last_q, sel, cap, cap_owner;
  logic [1:0]        rs_valid_q;
  logic [TAG_W-1:0]  rs_tag_q  [2];
  logic [DATA_W-1:0] rs_data_q [2];

  assign rq_valid = {bus.rq1_valid, bus.rq0_valid};
  assign rq_wren  = {bus.rq1_wren, bus.rq0_wren};
  assign rs_ready = {bus.rs1_ready, bus.rs0_ready};
  assign rs_pop   = rs_valid_q & rs_ready;

  always_comb begin
    in_flight = '0;
    for (int s = 0; s < MEM_LAT; s++) begin
      if (pipe_q[s].valid) in_flight[pipe_q[s].owner] = 1'b1;
    end
  end

  // One outstanding read per port; a read may enter only if its slot is free by the edge.
  assign can_go = rq_wren | (~in_flight & (~rs_valid_q | rs_pop));
  assign elig   = rq_valid & can_go;

  always_comb begin
    ready = '0;
    if (!reset) begin
      ready[0] = can_go[0] & (!elig[1] | last_q);
      ready[1] = can_go[1] & (!elig[0] | !last_q);
    end
  end

  assign grant = ready & rq_valid;
  assign sel   = grant[1];

  assign bus.rq0_ready   = ready[0];
  assign bus.rq1_ready   = ready[1];
  assign bus.mem_addr    = sel ? bus.rq1_addr   : bus.rq0_addr;
  assign bus.mem_wrdata  = sel ? bus.rq1_wrdata : bus.rq0_wrdata;
  assign bus.mem_rqaddr  = sel ? bus.rq1_tag    : bus.rq0_tag;
  assign bus.mem_wren    = |(grant & rq_wren);
  assign bus.mem_rqvalid = |(grant & ~rq_wren);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < MEM_LAT; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0].valid <= bus.mem_rqvalid;
      pipe_q[0].owner <= sel;
      for (int s = 1; s < MEM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  // Untracked memory responses (e.g. reads dropped by reset) fall through here.
  assign cap       = bus.mem_rdvalid & pipe_q[LastStage].valid;
  assign cap_owner = pipe_q[LastStage].owner;

  always_ff @(posedge clock) begin
    if (reset) begin
      rs_valid_q <= '0;
      for (int p = 0; p < 2; p++) begin
        rs_tag_q[p]  <= '0;
        rs_data_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (cap && (cap_owner == 1'(p))) begin
          rs_valid_q[p] <= 1'b1;
          rs_tag_q[p]   <= bus.mem_rdaddr;
          rs_data_q[p]  <= bus.mem_rddata;
        end else if (rs_pop[p]) begin
          rs_valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.rs0_valid = rs_valid_q[0];
  assign bus.rs0_tag   = rs_tag_q[0];
  assign bus.rs0_data  = rs_data_q[0];
  assign bus.rs1_valid = rs_valid_q[1];
  assign bus.rs1_tag   = rs_tag_q[1];
  assign bus.rs1_data  = rs_data_q[1];

`ifdef MYMEM_ARB_STATS_EN
  logic [31:0] grant0_q, grant1_q, conflict_q;
  logic        conflict;

  assign conflict = (&rq_valid) & (|grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (grant[0] && (grant0_q != '1)) grant0_q <= grant0_q + 32'd1;
      if (grant[1] && (grant1_q != '1)) grant1_q <= grant1_q + 32'd1;
      if (conflict && (conflict_q != '1)) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_mymem_arbiter.sv
// Self-checking bench for mymem_arbiter: directed cycle checks plus a response scoreboard
// fed by accepted reads; includes a behavioural single-port memory with 1-cycle read latency.
module tb_mymem_arbiter;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned MEM_LAT = 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mymem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

`ifdef MYMEM_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  mymem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef MYMEM_ARB_STATS_EN
    ,
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_conflict(stat_conflict)
`endif
  );

  // Behavioural memory, not reset, so reads in flight at reset still answer late.
  logic [DATA_W-1:0] mem [1024];
  logic              rd_pend = 1'b0;
  logic [TAG_W-1:0]  rd_tag  = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              spur    = 1'b0;

  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wrdata;
    rd_pend <= bus.mem_rqvalid;
    rd_tag  <= bus.mem_rqaddr;
    rd_data <= mem[bus.mem_addr];
  end

  assign bus.mem_rdvalid = rd_pend | spur;
  assign bus.mem_rdaddr  = rd_tag;
  assign bus.mem_rddata  = rd_data;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   rsp_cnt0 = 0;
  int   rsp_cnt1 = 0;
  rsp_t exp_q0[$];
  rsp_t exp_q1[$];
  rsp_t e0, e1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: accepted reads push the expected response, consumed responses pop it.
  always @(negedge clock) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      check_eq("one_grant", 64'(bus.rq0_valid & bus.rq0_ready & bus.rq1_valid & bus.rq1_ready),
               64'd0);
      if (bus.rq0_valid && bus.rq0_ready && !bus.rq0_wren)
        exp_q0.push_back({bus.rq0_tag, mem[bus.rq0_addr]});
      if (bus.rq1_valid && bus.rq1_ready && !bus.rq1_wren)
        exp_q1.push_back({bus.rq1_tag, mem[bus.rq1_addr]});
      if (bus.rs0_valid && bus.rs0_ready) begin
        rsp_cnt0++;
        if (exp_q0.size() == 0) check_eq("rs0_unexpected", 64'd1, 64'd0);
        else begin
          e0 = exp_q0.pop_front();
          check_eq("rs0_tag", 64'(bus.rs0_tag), 64'(e0.tag));
          check_eq("rs0_data", bus.rs0_data, e0.data);
        end
      end
      if (bus.rs1_valid && bus.rs1_ready) begin
        rsp_cnt1++;
        if (exp_q1.size() == 0) check_eq("rs1_unexpected", 64'd1, 64'd0);
        else begin
          e1 = exp_q1.pop_front();
          check_eq("rs1_tag", 64'(bus.rs1_tag), 64'(e1.tag));
          check_eq("rs1_data", bus.rs1_data, e1.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rq0_valid = 1'b0; bus.rq0_wren = 1'b0; bus.rq0_addr = '0;
    bus.rq0_wrdata = '0;  bus.rq0_tag = '0;
    bus.rq1_valid = 1'b0; bus.rq1_wren = 1'b0; bus.rq1_addr = '0;
    bus.rq1_wrdata = '0;  bus.rq1_tag = '0;
  endtask

  task automatic drive(input int p, input logic wr, input int addr, input logic [63:0] d,
                       input int tag);
    if (p == 0) begin
      bus.rq0_valid = 1'b1; bus.rq0_wren = wr; bus.rq0_addr = ADDR_W'(addr);
      bus.rq0_wrdata = d;   bus.rq0_tag = TAG_W'(tag);
    end else begin
      bus.rq1_valid = 1'b1; bus.rq1_wren = wr; bus.rq1_addr = ADDR_W'(addr);
      bus.rq1_wrdata = d;   bus.rq1_tag = TAG_W'(tag);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1;
    for (int i = 0; i < 1024; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 17);
    idle();
    bus.rs0_ready = 1'b1;
    bus.rs1_ready = 1'b1;

    // Reset: requests are never accepted while reset is high.
    reset = 1'b1;
    drive(0, 1'b0, 1, 64'd0, 1);
    drive(1, 1'b1, 2, 64'd7, 0);
    @(negedge clock);
    check_eq("rst_rq0_ready", 64'(bus.rq0_ready), 64'd0);
    check_eq("rst_rq1_ready", 64'(bus.rq1_ready), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    idle();
    @(negedge clock);
    check_eq("rst_rs0_valid", 64'(bus.rs0_valid), 64'd0);
    check_eq("rst_rs1_valid", 64'(bus.rs1_valid), 64'd0);
    check_eq("rst_rs0_tag", 64'(bus.rs0_tag), 64'd0);
    check_eq("rst_rs1_data", bus.rs1_data, 64'd0);
    check_eq("rst_mem_rqvalid", 64'(bus.mem_rqvalid), 64'd0);
    check_eq("rst_mem_wren", 64'(bus.mem_wren), 64'd0);

    // Write then read-back on port 0.
    cyc();
    drive(0, 1'b1, 5, 64'hDEAD_BEEF, 0);
    @(negedge clock);
    check_eq("t1_wr_ready", 64'(bus.rq0_ready), 64'd1);
    check_eq("t1_wr_wren", 64'(bus.mem_wren), 64'd1);
    check_eq("t1_wr_rqvalid", 64'(bus.mem_rqvalid), 64'd0);
    check_eq("t1_wr_addr", 64'(bus.mem_addr), 64'd5);
    cyc();
    drive(0, 1'b0, 5, 64'd0, 3);
    @(negedge clock);
    check_eq("t1_rd_ready", 64'(bus.rq0_ready), 64'd1);
    check_eq("t1_rd_rqvalid", 64'(bus.mem_rqvalid), 64'd1);
    check_eq("t1_rd_tag", 64'(bus.mem_rqaddr), 64'd3);
    cyc();
    idle();
    @(negedge clock);
    check_eq("t1_rs0_early", 64'(bus.rs0_valid), 64'd0);
    cyc();
    @(negedge clock);
    check_eq("t1_rs0_valid", 64'(bus.rs0_valid), 64'd1);
    check_eq("t1_rs0_tag", 64'(bus.rs0_tag), 64'd3);
    check_eq("t1_rs0_data", bus.rs0_data, 64'hDEAD_BEEF);
    check_eq("t1_rs1_valid", 64'(bus.rs1_valid), 64'd0);
    cyc();

    // Both ports streaming reads: strict alternation starting with port 0.
    do_reset();
    base0 = rsp_cnt0;
    base1 = rsp_cnt1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 10 + k, 64'd0, k);
      drive(1, 1'b0, 20 + k, 64'd0, 16 + k);
      @(negedge clock);
      check_eq("t2_grant0", 64'(bus.rq0_valid & bus.rq0_ready), 64'((k % 2) == 0));
      check_eq("t2_grant1", 64'(bus.rq1_valid & bus.rq1_ready), 64'((k % 2) == 1));
      check_eq("t2_rqvalid", 64'(bus.mem_rqvalid), 64'd1);
      cyc();
    end
    idle();
    repeat (3) cyc();
    check_eq("t2_rsp0_count", 64'(rsp_cnt0 - base0), 64'd4);
    check_eq("t2_rsp1_count", 64'(rsp_cnt1 - base1), 64'd4);

    // Port 1 backpressure: its reads stall, port 0 writes keep flowing.
    do_reset();
    bus.rs1_ready = 1'b0;
    drive(1, 1'b0, 7, 64'd0, 9);
    @(negedge clock);
    check_eq("t3_first_rd", 64'(bus.rq1_ready), 64'd1);
    cyc();
    for (int j = 1; j <= 6; j++) begin
      drive(0, 1'b1, 100 + j, 64'(j), 0);
      drive(1, 1'b0, 8, 64'd0, 10);
      @(negedge clock);
      check_eq("t3_rq1_stall", 64'(bus.rq1_ready), 64'd0);
      check_eq("t3_rq0_wr", 64'(bus.rq0_ready), 64'd1);
      if (j >= 2) check_eq("t3_rs1_held", 64'(bus.rs1_valid), 64'd1);
      cyc();
    end
    bus.rs1_ready = 1'b1;
    @(negedge clock);
    check_eq("t3_rq1_resume", 64'(bus.rq1_ready), 64'd1);
    check_eq("t3_rq0_lose", 64'(bus.rq0_ready), 64'd0);
    check_eq("t3_rs1_tag", 64'(bus.rs1_tag), 64'd9);
    cyc();
    idle();
    repeat (3) cyc();

    // Port 1 write passes a port 0 read blocked by its full slot.
    do_reset();
    bus.rs0_ready = 1'b0;
    drive(0, 1'b0, 3, 64'd0, 4);
    @(negedge clock);
    check_eq("t4_rd0_ready", 64'(bus.rq0_ready), 64'd1);
    cyc();
    cyc();
    drive(1, 1'b1, 200, 64'h55, 0);
    @(negedge clock);
    check_eq("t4_rs0_full", 64'(bus.rs0_valid), 64'd1);
    check_eq("t4_rq0_blocked", 64'(bus.rq0_ready), 64'd0);
    check_eq("t4_rq1_ready", 64'(bus.rq1_ready), 64'd1);
    check_eq("t4_mem_wren", 64'(bus.mem_wren), 64'd1);
    check_eq("t4_mem_rqvalid", 64'(bus.mem_rqvalid), 64'd0);
    check_eq("t4_mem_addr", 64'(bus.mem_addr), 64'd200);
    cyc();
    idle();
    bus.rs0_ready = 1'b1;
    repeat (3) cyc();

    // Reset right after a read grant: late and stray memory responses are dropped.
    do_reset();
    drive(0, 1'b0, 5, 64'd0, 2);
    @(negedge clock);
    check_eq("t5_rd_ready", 64'(bus.rq0_ready), 64'd1);
    cyc();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    spur = 1'b1;
    @(negedge clock);
    check_eq("t5_rs0_after_rst", 64'(bus.rs0_valid), 64'd0);
    cyc();
    spur = 1'b0;
    drive(0, 1'b0, 11, 64'd0, 6);
    drive(1, 1'b0, 12, 64'd0, 7);
    @(negedge clock);
    check_eq("t5_rs0_stray", 64'(bus.rs0_valid), 64'd0);
    check_eq("t5_grant0", 64'(bus.rq0_ready), 64'd1);
    check_eq("t5_grant1", 64'(bus.rq1_ready), 64'd0);
    cyc();
    idle();
    repeat (4) cyc();

`ifdef MYMEM_ARB_STATS_EN
    // Ten cycles of contending writes.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'b1, 300 + k, 64'(k), 0);
      drive(1, 1'b1, 400 + k, 64'(k), 0);
      cyc();
    end
    idle();
    @(negedge clock);
    check_eq("stat_grant0", 64'(stat_grant0), 64'd5);
    check_eq("stat_grant1", 64'(stat_grant1), 64'd5);
    check_eq("stat_conflict", 64'(stat_conflict), 64'd10);
    cyc();
`endif

    check_eq("sb_left0", 64'(exp_q0.size()), 64'd0);
    check_eq("sb_left1", 64'(exp_q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
